vga_top: RTL and testbench

VGA_TOP -- requirements
Module: vga_top

---
 rtl/vga_pkg.sv | 69 ++++++
 rtl/vga_if.sv | 24 ++
 rtl/font_rom.sv | 34 +++
 rtl/vga_top.sv | 107 ++++++++++
 tb/tb_vga_top.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing, text-region geometry, colours and glyph codes
// for the 640x480 text overlay generator.
package vga_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Three 3-character strings stacked vertically, one region per switch
    localparam logic [9:0] TEXT_X0     = 10'd256;
    localparam logic [9:0] TEXT_W      = 10'd24;
    localparam logic [9:0] TEXT_Y0     = 10'd64;
    localparam logic [9:0] TEXT_PITCH  = 10'd64;
    localparam logic [9:0] TEXT_ROWS   = 10'd16;
    localparam int         NUM_REGIONS = 3;

    localparam logic [2:0] RGB_OFF   = 3'b000;
    localparam logic [2:0] RGB_RED   = 3'b100;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_BLUE  = 3'b001;

    typedef enum logic [2:0] {
        CH_S = 3'd0,
        CH_W = 3'd1,
        CH_1 = 3'd2,
        CH_2 = 3'd3,
        CH_3 = 3'd4
    } char_t;

    function automatic logic [9:0] region_y0(input logic [1:0] r);
        return TEXT_Y0 + TEXT_PITCH * {8'd0, r};
    endfunction

    // Region r shows "SW" followed by the digit r+1
    function automatic char_t region_char(input logic [1:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    return CH_S;
            2'd1:    return CH_W;
            default: begin
                case (r)
                    2'd0:    return CH_1;
                    2'd1:    return CH_2;
                    default: return CH_3;
                endcase
            end
        endcase
    endfunction

    function automatic logic [2:0] region_colour(input logic [1:0] r);
        case (r)
            2'd0:    return RGB_RED;
            2'd1:    return RGB_GREEN;
            default: return RGB_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster output bundle plus the region-enable switches.
// Free-running stream: every pixel is valid, there is no valid/ready handshake.
interface vga_if;
    logic       swt1;
    logic       swt2;
    logic       swt3;
    logic [2:0] rgb_text;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [2:0] text_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    modport master (
        input  swt1, swt2, swt3,
        output rgb_text, hsync, vsync, video_on, text_on, pixel_x, pixel_y
    );

    modport slave (
        output swt1, swt2, swt3,
        input  rgb_text, hsync, vsync, video_on, text_on, pixel_x, pixel_y
    );
endinterface

// File: rtl/font_rom.sv
// 8x16 glyph ROM for S, W, 1, 2, 3; row 0 is the top scanline and
// bit 7 of the returned pattern is the leftmost pixel.
module font_rom
    import vga_pkg::*;
(
    input  char_t      code,
    input  logic [3:0] row,
    output logic [7:0] pattern
);

    // Each glyph packs its 16 rows MSB-first: row 0 in bits [127:120]
    localparam logic [127:0] GLYPH_S = 128'h00007CC6C0C060380C0606C67C000000;
    localparam logic [127:0] GLYPH_W = 128'h0000C6C6C6C6C6D6D6FEEEC6C6000000;
    localparam logic [127:0] GLYPH_1 = 128'h0000183878181818181818187E000000;
    localparam logic [127:0] GLYPH_2 = 128'h00007CC606060C183060C0FE00000000;
    localparam logic [127:0] GLYPH_3 = 128'h00007CC606063C060606C67C00000000;

    logic [127:0] glyph;
    logic [6:0]   lsb;

    always_comb begin
        case (code)
            CH_S:    glyph = GLYPH_S;
            CH_W:    glyph = GLYPH_W;
            CH_1:    glyph = GLYPH_1;
            CH_2:    glyph = GLYPH_2;
            CH_3:    glyph = GLYPH_3;
            default: glyph = '0;
        endcase
        lsb     = {4'd15 - row, 3'b000};
        pattern = glyph[lsb +: 8];
    end

endmodule

// File: rtl/vga_top.sv
// 640x480 raster generator with three switch-enabled text strings:
// pixel divider, h/v counters, registered syncs, region decode, colour mux.
module vga_top
    import vga_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    vga_if.master vga
);

    logic [1:0] div;
    logic       tick;
    logic [9:0] h_count, v_count;
    logic [9:0] h_next, v_next;
    logic       hsync_q, vsync_q;

    assign tick = (div == 2'd3);

    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (tick) begin
            if (h_count == H_TOTAL - 10'd1) begin
                h_next = '0;
                v_next = (v_count == V_TOTAL - 10'd1) ? '0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
    end

    // Syncs are computed from the next counter values so they line up with pixel_x/pixel_y
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div     <= '0;
            h_count <= '0;
            v_count <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div     <= div + 2'd1;
            h_count <= h_next;
            v_count <= v_next;
            hsync_q <= ~((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END));
            vsync_q <= ~((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END));
        end
    end

    logic       video_on;
    logic [2:0] sw;
    logic       in_x;
    logic [2:0] in_region;
    logic [1:0] region;
    logic [4:0] col;
    logic [3:0] row;
    logic [2:0] bit_sel;
    char_t      ch;
    logic [7:0] font_row;
    logic       font_bit;
    logic [2:0] text_on;
    logic [2:0] rgb;

    assign video_on = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
    assign sw       = {vga.swt3, vga.swt2, vga.swt1};

    // Regions share one x band and never overlap, so a single glyph lookup serves all three
    always_comb begin
        in_x      = (h_count >= TEXT_X0) && (h_count < TEXT_X0 + TEXT_W);
        in_region = '0;
        region    = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (in_x && (v_count >= region_y0(2'(i))) &&
                (v_count < region_y0(2'(i)) + TEXT_ROWS)) begin
                in_region[i] = 1'b1;
                region       = 2'(i);
            end
        end
        col     = 5'(h_count - TEXT_X0);
        row     = 4'(v_count - region_y0(region));
        bit_sel = 3'd7 - col[2:0];
        ch      = region_char(region, col[4:3]);
    end

    font_rom u_font_rom (
        .code    (ch),
        .row     (row),
        .pattern (font_row)
    );

    always_comb begin
        font_bit = font_row[bit_sel];
        text_on  = in_region & sw & {3{video_on}};
        rgb      = RGB_OFF;
        if ((|text_on) && font_bit) begin
            rgb = region_colour(region);
        end
    end

    assign vga.pixel_x  = h_count;
    assign vga.pixel_y  = v_count;
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.video_on = video_on;
    assign vga.text_on  = text_on;
    assign vga.rgb_text = rgb;

endmodule

// File: tb/tb_vga_top.sv
// Scoreboard bench for vga_top: the driver walks the raster to chosen points
// and queues expected outputs; a monitor pops and compares them.
module tb_vga_top;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vga_if vif ();

    vga_top dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was released; the whole model derives from it
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [28:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    event        sample_ev;

    localparam logic [127:0] G_S = 128'h00007CC6C0C060380C0606C67C000000;
    localparam logic [127:0] G_W = 128'h0000C6C6C6C6C6D6D6FEEEC6C6000000;
    localparam logic [127:0] G_1 = 128'h0000183878181818181818187E000000;
    localparam logic [127:0] G_2 = 128'h00007CC606060C183060C0FE00000000;
    localparam logic [127:0] G_3 = 128'h00007CC606063C060606C67C00000000;

    function automatic logic [127:0] tb_glyph(input int code);
        case (code)
            0:       return G_S;
            1:       return G_W;
            2:       return G_1;
            3:       return G_2;
            default: return G_3;
        endcase
    endfunction

    // Expected {hsync, vsync, video_on, text_on, rgb_text, pixel_x, pixel_y}
    function automatic logic [28:0] model(input int k, input logic [2:0] sw);
        int p, x, y, chi, gx, gy;
        logic hs, vs, von;
        logic [2:0] ton, rgb;
        logic [127:0] g;
        p   = k / 4;
        x   = p % 800;
        y   = (p / 800) % 525;
        hs  = !(x >= 656 && x <= 751);
        vs  = !(y >= 490 && y <= 491);
        von = (x < 640) && (y < 480);
        ton = 3'b000;
        rgb = 3'b000;
        for (int r = 0; r < 3; r++) begin
            if (x >= 256 && x < 280 && y >= 64 + 64 * r && y < 80 + 64 * r && sw[r] && von) begin
                ton[r] = 1'b1;
                chi = (x - 256) / 8;
                gx  = (x - 256) % 8;
                gy  = y - 64 - 64 * r;
                g   = tb_glyph(chi < 2 ? chi : 2 + r);
                if (g[127 - (gy * 8 + gx)])
                    rgb = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 : 3'b001;
            end
        end
        return {hs, vs, von, ton, rgb, 10'(x), 10'(y)};
    endfunction

    function automatic int pix_k(input int x, input int y);
        return 4 * (y * 800 + x);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name);
        exp_q.push_back(model(cyc, {vif.swt3, vif.swt2, vif.swt1}));
        name_q.push_back(name);
    endtask

    task automatic goto_k(input int k);
        while (cyc < k) step();
    endtask

    initial begin : monitor
        logic [28:0] e, a;
        string nm;
        forever begin
            @(negedge clk or sample_ev);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {vif.hsync, vif.vsync, vif.video_on, vif.text_on, vif.rgb_text,
                      vif.pixel_x, vif.pixel_y};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got hs=%b vs=%b von=%b ton=%b rgb=%b x=%0d y=%0d, want hs=%b vs=%b von=%b ton=%b rgb=%b x=%0d y=%0d",
                             nm, a[28], a[27], a[26], a[25:23], a[22:20], a[19:10], a[9:0],
                             e[28], e[27], e[26], e[25:23], e[22:20], e[19:10], e[9:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #40_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    logic [2:0] sw_pat [4] = '{3'b111, 3'b110, 3'b101, 3'b011};

    initial begin : driver
        int y;
        vif.swt1 = 1'b0;
        vif.swt2 = 1'b0;
        vif.swt3 = 1'b0;

        repeat (3) begin
            step();
            check("reset_hold");
        end
        reset = 1'b1;
        check("release_k0");

        // Every clock of the first line and into the second: hsync window and wrap
        for (int k = 1; k <= 3204; k++) begin
            step();
            check(k == 4 ? "px1_after_4clk" : "line_scan");
        end

        // Text regions under varying switch patterns
        for (int r = 0; r < 3; r++) begin
            for (int row = 0; row < 16; row++) begin
                y = 64 + 64 * r + row;
                {vif.swt3, vif.swt2, vif.swt1} = sw_pat[row % 4];
                for (int x = 252; x <= 283; x++) begin
                    goto_k(pix_k(x, y));
                    if (y == 66 && x == 258) begin
                        vif.swt1 = 1'b0;
                        check("swt1_off_258_66");
                        step();
                        vif.swt1 = 1'b1;
                        check("swt1_on_258_66");
                    end else begin
                        check("text_scan");
                    end
                end
                goto_k(pix_k(640, y));
                {vif.swt3, vif.swt2, vif.swt1} = 3'b111;
                check("hblank_x640");
            end
        end

        // Remaining lines: vertical blanking and vsync window
        for (int yy = 208; yy < 525; yy++) begin
            goto_k(pix_k(0, yy));
            check("vsweep_x0");
            goto_k(pix_k(799, yy));
            check("vsweep_x799");
        end
        goto_k(pix_k(799, 524) + 3);
        check("frame_last_clk");
        goto_k(1680000);
        check("frame_wrap_00");

        // Asynchronous reset mid-frame at (400,300)
        goto_k(1680000 + pix_k(400, 300));
        check("pre_reset_400_300");
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_immediate");
        ->sample_ev;
        repeat (2) begin
            step();
            check("reset_hold_mid");
        end
        reset = 1'b1;
        repeat (4) step();
        check("resume_x1");

        step();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
